// File: rtl/result_collector_pkg.sv
// Shared types and constants for the complex-ALU result collector.
// Entry layout is {re, im, seq}, most significant field first.
package result_collector_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int SEQ_W_DEF  = 5;
  localparam int DEPTH_DEF  = 8;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] re;
    logic [DATA_W_DEF-1:0] im;
    logic [SEQ_W_DEF-1:0]  seq;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Generic first-word-fall-through FIFO: head is visible on rdata
// whenever not empty, and reads back as zero while empty.
module result_fifo
  import result_collector_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  // Storage array; no reset, contents are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally; occupancy tracks push/pop balance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_collector.sv
// Captures ALU results on the ready rising edge, tags them and queues them.
// Define RESULT_COLLECTOR_CHECKSUM_EN to add a running checksum output.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int SEQ_W  = SEQ_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_ready,
  input  logic [DATA_W-1:0]        in_real,
  input  logic [DATA_W-1:0]        in_imag,
  input  logic                     rd_en,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_real,
  output logic [DATA_W-1:0]        out_imag,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     full,
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
  output logic [7:0]               checksum,
`endif
  output logic                     overflow
);

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic [SEQ_W-1:0]  seq;
  } rec_t;

  localparam int RW = $bits(rec_t);

  logic             ready_d;
  logic             accept;
  logic             pop;
  logic             wr;
  logic             empty;
  logic [SEQ_W-1:0] seq;
  rec_t             wrec;
  rec_t             head;
  logic [RW-1:0]    rdata;

  assign accept = in_ready & ~ready_d;
  assign pop    = rd_en & out_valid;
  assign wr     = accept & (~full | pop);

  assign wrec.re  = in_real;
  assign wrec.im  = in_imag;
  assign wrec.seq = seq;

  assign out_valid = ~empty;
  assign head      = rec_t'(rdata);
  assign out_real  = head.re;
  assign out_imag  = head.im;
  assign out_seq   = head.seq;

  result_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr),
    .pop   (pop),
    .wdata (wrec),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Edge detect, sequence tagging and sticky drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_d  <= 1'b0;
      seq      <= '0;
      overflow <= 1'b0;
    end else begin
      ready_d <= in_ready;
      if (accept)       seq      <= seq + 1'b1;
      if (accept && !wr) overflow <= 1'b1;
    end
  end

`ifdef RESULT_COLLECTOR_CHECKSUM_EN
  // Running byte sum over every entry actually written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (wr) begin
      checksum <= checksum + 8'(in_real) + 8'(in_imag);
    end
  end
`endif

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: a reference model predicts
// every output each cycle; popped entries are checked against a queue.
module tb_result_collector;
  import result_collector_pkg::*;

  localparam int DW = 4;
  localparam int D  = 8;
  localparam int SW = 5;
  localparam int CW = cnt_w(D);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_ready = 1'b0;
  logic [DW-1:0] in_real = '0;
  logic [DW-1:0] in_imag = '0;
  logic          rd_en = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_imag;
  logic [SW-1:0] out_seq;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  result_collector #(
    .DATA_W (DW),
    .DEPTH  (D),
    .SEQ_W  (SW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .rd_en     (rd_en),
    .out_valid (out_valid),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_seq   (out_seq),
    .count     (count),
    .full      (full),
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int seq;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mseq = 0;
  int   movf = 0;
  int   mprev = 0;
  int   msum = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compare outputs against the model, then advance one clock.
  task automatic step(input bit rdy, input int re, input int im,
                      input bit rd);
    bit acc;
    bit pop;
    bit wr;
    in_ready = rdy;
    in_real  = DW'(re);
    in_imag  = DW'(im);
    rd_en    = rd;
    check("valid", 32'(out_valid), 32'(q.size() != 0));
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == D));
    check("ovf", 32'(overflow), 32'(movf));
    if (q.size() != 0) begin
      check("head_re", 32'(out_real), 32'(q[0].re));
      check("head_im", 32'(out_imag), 32'(q[0].im));
      check("head_seq", 32'(out_seq), 32'(q[0].seq));
    end else begin
      check("empty_out", {out_real, out_imag, out_seq}, 32'd0);
    end
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    check("csum", 32'(checksum), 32'(msum));
`endif
    acc = rdy && (mprev == 0);
    pop = rd && (q.size() != 0);
    wr  = acc && ((q.size() < D) || pop);
    if (pop) void'(q.pop_front());
    if (wr) begin
      q.push_back('{re & 15, im & 15, mseq});
      msum = (msum + (re & 15) + (im & 15)) % 256;
    end
    if (acc && !wr) movf = 1;
    if (acc) mseq = (mseq + 1) % (1 << SW);
    mprev = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic result(input int re, input int im, input bit rd);
    step(1'b1, re, im, rd);
    step(1'b0, re, im, rd);
  endtask

  task automatic do_reset(input bit rdy_hold);
    reset    = 1'b0;
    in_ready = rdy_hold;
    rd_en    = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_out", {out_real, out_imag, out_seq}, 32'd0);
    q.delete();
    mseq  = 0;
    movf  = 0;
    mprev = 0;
    msum  = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < D + 2; i++) step(1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    do_reset(1'b0);
    step(1'b0, 0, 0, 1'b0);

    result(3, 5, 1'b0);
    check("t1_seq0", 32'(out_seq), 32'd0);
    check("t1_re3", 32'(out_real), 32'd3);

    for (int i = 0; i < 4; i++) step(1'b1, 7, 2, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    check("t2_one", 32'(count), 32'd2);
    result(1, 1, 1'b0);
    drain();

    do_reset(1'b0);
    for (int i = 0; i < 9; i++) result(i, 15 - i, 1'b0);
    check("t3_full", 32'(full), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd1);
    drain();
    result(4, 4, 1'b0);
    check("t3_seq9", 32'(out_seq), 32'd9);
    drain();

    do_reset(1'b0);
    for (int i = 0; i < 8; i++) result(i, i, 1'b0);
    result(9, 6, 1'b1);
    check("t4_cnt", 32'(count), 32'd7);
    check("t4_ovf", 32'(overflow), 32'd0);
    drain();

    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1);
    result(2, 3, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    check("t5_empty", 32'(count), 32'd0);

    do_reset(1'b0);
    for (int i = 0; i < 5; i++) result(i + 1, i, 1'b0);
    do_reset(1'b1);
    step(1'b1, 6, 6, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    check("t6_seq0", 32'(out_seq), 32'd0);
    drain();

    do_reset(1'b0);
    result(3, 5, 1'b0);
    result(15, 15, 1'b0);
    step(1'b0, 0, 0, 1'b0);
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    check("csum38", 32'(checksum), 32'd38);
`endif
    drain();

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
